// File: rtl/pipeline_pkg.sv
// Shared constants for the MIPS pipeline stages: widths, default reset PC, NOP word.
// Pure definitions, no latency, no flow control.
package pipeline_pkg;

    localparam int          XLEN               = 32;
    localparam int          WORD_BYTES         = 4;
    localparam int unsigned IMEM_DEPTH_DEFAULT = 1024;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;

    function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] byte_addr);
        return {2'b00, byte_addr[XLEN-1:2]};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC mux (redirect > hold > +4) and IMEM range check; 0-cycle pc out.
// hold_i freezes the PC; a redirect always wins over hold.
module pc_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            hold_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic            out_of_range_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i & ~32'd3;
        end else if (!hold_i) begin
            pc_d = pc_q + 32'(WORD_BYTES);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o           = pc_q;
    assign out_of_range_o = word_index(pc_q) >= IMEM_DEPTH;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC drives imem_addr combinationally, instruction lands in IF/ID one cycle later.
// stall holds PC and IF/ID; redirect squashes the wrong-path fetch; a fault halts fetch until reset.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter logic [31:0] NOP        = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instruction,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc4,
    output logic            if_id_valid,
    output logic [XLEN-1:0] pc,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fetch_count
);

    logic [XLEN-1:0] pc_cur;
    logic            out_of_range;
    logic            fault_now;

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] count_q, count_d;

    // A latched fault or an out-of-range PC both freeze fetch this cycle.
    assign fault_now = fault_q | out_of_range;

    pc_reg #(
        .RESET_PC   (RESET_PC),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_pc_reg (
        .clk_i          (clk),
        .rst_ni         (rst),
        .hold_i         (stall | fault_now),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .pc_o           (pc_cur),
        .out_of_range_o (out_of_range)
    );

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;
        if (redirect) begin
            instr_d = NOP;
            valid_d = 1'b0;
            fault_d = fault_q | (redirect_pc[1:0] != 2'b00);
        end else if (fault_now) begin
            instr_d = NOP;
            valid_d = 1'b0;
            fault_d = 1'b1;
        end else if (!stall) begin
            instr_d = imem_instruction;
            pc4_d   = pc_cur + 32'(WORD_BYTES);
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = word_index(pc_cur);
    assign pc          = pc_cur;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_fault = fault_q;
    assign fetch_count = count_q;

endmodule
